// File: rtl/countdown_pkg.sv
// countdown_m shared types and default widths.
package countdown_pkg;
    localparam int CD_WIDTH = 5;
    localparam int CD_PRE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/prescaler_m.sv
// Tick divider for countdown_m: one tick every (i_div+1) enabled cycles.
// Compiled only when PRESCALE_EN is defined.
`ifdef PRESCALE_EN
module prescaler_m
    import countdown_pkg::*;
#(
    parameter int PRE_W = CD_PRE_W
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [PRE_W-1:0] i_div,
    output logic             o_tick
);
    logic [PRE_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == i_div);
    assign o_tick = i_en && w_wrap && !i_clr;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + PRE_W'(1);
        end
    end
endmodule
`endif

// File: rtl/countdown_m.sv
// Loadable down-counter/timer with one-shot or auto-reload operation.
// Optional prescaler on the count enable when PRESCALE_EN is defined.
module countdown_m
    import countdown_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH,
    parameter int PRE_W = CD_PRE_W
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             auto_reload,
`ifdef PRESCALE_EN
    input  logic [PRE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             w_step;

`ifdef PRESCALE_EN
    prescaler_m #(
        .PRE_W (PRE_W)
    ) u_pre (
        .clk    (clk),
        .rst_   (rst_),
        .i_clr  (load),
        .i_en   (en),
        .i_div  (prescale),
        .o_tick (w_step)
    );
`else
    assign w_step = en;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    // A zero load parks in IDLE so the count can never wrap to all-ones.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        if (load) begin
            w_count_nxt  = data;
            w_reload_nxt = data;
            w_state_nxt  = (data != '0) ? RUN : IDLE;
        end else if (r_state == RUN && w_step) begin
            if (r_count > WIDTH'(1)) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else begin
                w_tc_nxt = 1'b1;
                if (auto_reload) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = DONE;
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
endmodule

// File: tb/tb_countdown_m.sv
// Scoreboard bench for countdown_m: stimulus pushes expectations,
// a monitor pops and compares after every rising edge.
module tb_countdown_m;
    localparam int W = 5;
    localparam int PW = 4;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk;
    logic         rst_;
    logic         load;
    logic [W-1:0] data;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;
`ifdef PRESCALE_EN
    logic [PW-1:0] prescale;
`endif

    exp_t q[$];
    int   n_vec;
    int   n_err;

    countdown_m #(
        .WIDTH (W),
        .PRE_W (PW)
    ) dut (
        .clk         (clk),
        .rst_        (rst_),
        .load        (load),
        .data        (data),
        .en          (en),
        .auto_reload (auto_reload),
`ifdef PRESCALE_EN
        .prescale    (prescale),
`endif
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".count"}, int'(count), int'(e.cnt));
        chk({tag, ".tc"}, int'(tc), int'(e.tc));
        chk({tag, ".busy"}, int'(busy), int'(e.busy));
        chk({tag, ".done"}, int'(done), int'(e.done));
    endtask

    // Monitor: every edge with a pending expectation is checked 1 ns later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk_all("mon", e);
        end
    end

    task automatic cyc(input logic ld, input int d, input logic e,
                       input logic ar, input int c, input logic t,
                       input logic b, input logic dn);
        exp_t x;
        @(negedge clk);
        load        = ld;
        data        = W'(d);
        en          = e;
        auto_reload = ar;
        x.cnt  = W'(c);
        x.tc   = t;
        x.busy = b;
        x.done = dn;
        q.push_back(x);
    endtask

    initial begin
        exp_t z;
        n_vec = 0;
        n_err = 0;
        load = 0;
        data = '0;
        en = 0;
        auto_reload = 0;
`ifdef PRESCALE_EN
        prescale = '0;
`endif
        rst_ = 1'b0;
        #12;
        z = '0;
        chk_all("reset", z);
        rst_ = 1'b1;

        // one-shot from 3
        cyc(1, 3, 1, 0, 3, 0, 1, 0);
        cyc(0, 0, 1, 0, 2, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, 0, 1);

        // periodic from 2
        cyc(1, 2, 1, 1, 2, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 2, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 2, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 0, 1, 0);

        // enable gaps, then load wins over a due terminal count
        cyc(1, 4, 1, 0, 4, 0, 1, 0);
        cyc(0, 0, 1, 0, 3, 0, 1, 0);
        cyc(0, 0, 0, 0, 3, 0, 1, 0);
        cyc(0, 0, 0, 0, 3, 0, 1, 0);
        cyc(0, 0, 1, 0, 2, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0, 1, 0);
        cyc(1, 7, 1, 0, 7, 0, 1, 0);
        cyc(0, 0, 1, 0, 6, 0, 1, 0);

        // reload value 1 in periodic mode
        cyc(1, 1, 1, 1, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0, 1, 0);

        // zero load never wraps
        cyc(1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 0, 0, 0, 0);

        // asynchronous reset mid-run
        cyc(1, 5, 1, 0, 5, 0, 1, 0);
        cyc(0, 0, 1, 0, 4, 0, 1, 0);
        cyc(0, 0, 1, 0, 3, 0, 1, 0);
        @(negedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        z = '0;
        chk_all("async_rst", z);
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0);

`ifdef PRESCALE_EN
        prescale = PW'(2);
        cyc(1, 2, 1, 0, 2, 0, 1, 0);
        cyc(0, 0, 1, 0, 2, 0, 1, 0);
        cyc(0, 0, 1, 0, 2, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
`endif

        // drain the scoreboard with a bounded wait
        @(negedge clk);
        load = 0;
        en = 0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
